// File: rtl/gm64_pkg.sv
// -----------------------------------------------------------------------------
// gm64_pkg
//   Shared types and constants for the gm64 memory arbiter slice.
//   - arb_state_t : arbiter transaction sequencer states
//   - REQ_VIC / REQ_CPU : requester IDs, also used as bit index into grant
//   - field widths of the memCtrl request bus
// -----------------------------------------------------------------------------
package gm64_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  localparam int REQ_VIC = 0;
  localparam int REQ_CPU = 1;

  localparam int ADDR_W = 16;
  localparam int BANK_W = 6;
  localparam int DATA_W = 8;

endpackage : gm64_pkg

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
//   Winner selection between the VIC and CPU requesters, plus the starvation
//   counter that forces the CPU through after STARVE_LIMIT consecutive VIC
//   wins while the CPU was waiting.
//
//   Build option: MEM_ARB_STARVE_GUARD_EN
//     defined     : starvation counter and forced CPU grant are present.
//     not defined : pure fixed priority, VIC always wins a tie; the counter
//                   is not built and STARVE_LIMIT has no effect.
//
// Ports
//   clk, reset   clock, asynchronous active-low reset
//   i_idle       arbiter is in IDLE (the only state where a win is taken)
//   i_vic_req    VIC request pending
//   i_cpu_req    CPU request pending
//   o_win        some request wins this cycle (combinational)
//   o_win_id     winner ID: REQ_VIC or REQ_CPU (combinational)
// -----------------------------------------------------------------------------
module mem_arb_pick
  import gm64_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_idle,
  input  logic i_vic_req,
  input  logic i_cpu_req,
  output logic o_win,
  output logic o_win_id
);

  logic w_force_cpu;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_cpu = (r_starve_cnt == LIMIT);

  // The counter only moves on IDLE cycles: a VIC win over a waiting CPU
  // counts up (saturating), a CPU win or an absent CPU request clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (i_idle) begin
      if (!i_cpu_req || (o_win_id == 1'(REQ_CPU))) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_pick;
  localparam int unused_starve_limit = STARVE_LIMIT;

  assign w_force_cpu   = 1'b0;
  assign w_unused_pick = ^{clk, reset, i_idle};
`endif

  // CPU wins when it is alone, or when the guard forces it on a tie.
  assign o_win    = i_vic_req | i_cpu_req;
  assign o_win_id = i_cpu_req & (~i_vic_req | w_force_cpu);

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one PSRAM memCtrl between the VIC (read-only video fetch) and the
//   CPU (read/write). One request is latched at a time in IDLE, memCtrl's
//   CE / isBusy handshake is sequenced, and the winner gets a one-cycle ack
//   with its read data. VIC has fixed priority; an optional starvation guard
//   bounds CPU wait time (see mem_arb_pick, macro MEM_ARB_STARVE_GUARD_EN).
//
//   Sequence: IDLE -(win)-> ISSUE (mem_ce high for one cycle, one cycle after
//   the grant) -> WAIT_BUSY -(busy)-> WAIT_DONE -(!busy)-> DONE (ack) -> IDLE.
//   WAIT_BUSY aborts to DONE with timeout/ack if isBusy never rises.
//   All outputs are registered.
//
// Parameters
//   STARVE_LIMIT   consecutive VIC wins over a waiting CPU (1..15)
//   START_TIMEOUT  cycles from mem_ce to abort if isBusy stays low (1..255)
//
// Ports
//   clk, reset                 clkRAM, asynchronous active-low reset
//   vic_req/addr/bank          VIC read request, held until vic_ack
//   vic_ack, vic_rdata         VIC completion pulse and held read data
//   cpu_req/we/addr/bank/wdata CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata         CPU completion pulse and held read data
//   mem_ce/write/addr/bank/wdata  to memCtrl
//   mem_rdata, mem_busy, mem_ready from memCtrl (mem_ready is not needed)
//   grant                      current owner, bit0 VIC, bit1 CPU
//   timeout                    one-cycle pulse on an aborted transaction
// -----------------------------------------------------------------------------
module mem_arbiter
  import gm64_pkg::*;
#(
  parameter int STARVE_LIMIT  = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              vic_req,
  input  logic [ADDR_W-1:0] vic_addr,
  input  logic [BANK_W-1:0] vic_bank,
  output logic              vic_ack,
  output logic [DATA_W-1:0] vic_rdata,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BANK_W-1:0] cpu_bank,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  output logic              mem_ce,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BANK_W-1:0] mem_bank,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_ready,

  output logic [1:0]        grant,
  output logic              timeout
);

  // Abort once this many cycles have passed since mem_ce went high.
  localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);

  arb_state_t        r_state;
  logic              r_owner;      // REQ_VIC or REQ_CPU of the current transaction
  logic              r_mem_ce;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BANK_W-1:0] r_mem_bank;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_grant;
  logic              r_vic_ack;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_vic_rdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_timeout;
  logic [7:0]        r_tmo_cnt;

  logic              w_idle;
  logic              w_win;
  logic              w_win_id;
  logic              w_unused_ready;

  assign w_idle         = (r_state == IDLE);
  assign w_unused_ready = mem_ready;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .i_idle    (w_idle),
    .i_vic_req (vic_req),
    .i_cpu_req (cpu_req),
    .o_win     (w_win),
    .o_win_id  (w_win_id)
  );

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values sampled at the same edge; blocking = in a
  // clocked block would let later lines see already-updated state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_bank  <= '0;
      r_mem_wdata <= '0;
      r_grant     <= 2'b00;
      r_vic_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vic_rdata <= '0;
      r_cpu_rdata <= '0;
      r_timeout   <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      // Pulses default low; only the entry into DONE raises them.
      r_vic_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_timeout <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_win) begin
            r_owner <= w_win_id;
            r_state <= ISSUE;
            if (w_win_id == 1'(REQ_CPU)) begin
              r_grant     <= 2'b10;
              r_mem_write <= cpu_we;
              r_mem_addr  <= cpu_addr;
              r_mem_bank  <= cpu_bank;
              r_mem_wdata <= cpu_wdata;
            end else begin
              r_grant     <= 2'b01;
              r_mem_write <= 1'b0;
              r_mem_addr  <= vic_addr;
              r_mem_bank  <= vic_bank;
              r_mem_wdata <= '0;
            end
          end
        end

        // First ISSUE cycle raises mem_ce, second drops it and moves on,
        // so CE is high for exactly one cycle starting one edge after grant.
        ISSUE: begin
          if (!r_mem_ce) begin
            r_mem_ce <= 1'b1;
          end else begin
            r_mem_ce  <= 1'b0;
            r_tmo_cnt <= 8'd1;
            r_state   <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (mem_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_tmo_cnt >= TMO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= DONE;
            if (r_owner == 1'(REQ_CPU)) begin
              r_cpu_ack <= 1'b1;
              if (!r_mem_write) r_cpu_rdata <= '0;
            end else begin
              r_vic_ack   <= 1'b1;
              r_vic_rdata <= '0;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        WAIT_DONE: begin
          if (!mem_busy) begin
            r_state <= DONE;
            if (r_owner == 1'(REQ_CPU)) begin
              r_cpu_ack <= 1'b1;
              if (!r_mem_write) r_cpu_rdata <= mem_rdata;
            end else begin
              r_vic_ack   <= 1'b1;
              r_vic_rdata <= mem_rdata;
            end
          end
        end

        // Ack is high during this cycle; release the bus and go idle.
        DONE: begin
          r_grant <= 2'b00;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign vic_ack   = r_vic_ack;
  assign vic_rdata = r_vic_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign mem_ce    = r_mem_ce;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_bank  = r_mem_bank;
  assign mem_wdata = r_mem_wdata;
  assign grant     = r_grant;
  assign timeout   = r_timeout;

endmodule : mem_arbiter
